mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register in the 5-stage MIPS32 core.
- Takes the registered EX/MEM fields and runs loads and stores against a variable-latency data memory over a REQ/ACK handshake.
- Holds STALL to freeze the upstream pipeline while an access is outstanding.
- Drives the MEM/WB register fields; non-memory instructions pass through with no added latency.

Parameters:
- WORD_LEN, 32, data/address/PC width (matches `WORD_LEN).
- REG_ADDR_LEN, 5, register-file address width (matches `REG_ADDR_LEN).
- ACK_TIMEOUT, 255, max cycles in WAIT before abort; must be >=1.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- WB_EN_IN  in  1  from EX/MEM
- MEM_READ_EN_IN  in  1  from EX/MEM, load
- MEM_WRITE_EN_IN  in  1  from EX/MEM, store
- PC_IN  in  WORD_LEN  from EX/MEM
- ALU_RESULT_IN  in  WORD_LEN  from EX/MEM, byte address or ALU value
- SW_OPERAND_IN  in  WORD_LEN  from EX/MEM, store data
- DESTINATION_IN  in  REG_ADDR_LEN  from EX/MEM
- MEM_REQ  out  1  request valid
- MEM_WE  out  1  1=write, 0=read
- MEM_ADDR  out  WORD_LEN  word-aligned byte address
- MEM_WDATA  out  WORD_LEN  store data
- MEM_ACK  in  1  one-cycle completion strobe from memory
- MEM_RDATA  in  WORD_LEN  valid when MEM_ACK=1
- STALL  out  1  combinational, freezes PC/IF/ID/EX/EX-MEM registers
- BUS_ERR  out  1  one-cycle pulse on timeout
- WB_EN_OUT_REG  out  1  to MEM/WB
- MEM_READ_EN_OUT_REG  out  1  to MEM/WB, WB mux select
- PC_OUT_REG  out  WORD_LEN  to MEM/WB
- ALU_RESULT_OUT_REG  out  WORD_LEN  to MEM/WB
- MEM_DATA_OUT_REG  out  WORD_LEN  to MEM/WB, load data
- DESTINATION_OUT_REG  out  REG_ADDR_LEN  to MEM/WB

Behaviour:
- Reset: RESET=1 at a CLK edge forces state IDLE, timeout counter 0, and every registered output (MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR, all *_OUT_REG) to 0.
  - Applies mid-access: REQ drops the next cycle and any late MEM_ACK is ignored.
- op = MEM_READ_EN_IN | MEM_WRITE_EN_IN. If both are set, the access is a read and the write is suppressed.
- IDLE, op=0 (pass-through): STALL=0. Next edge, MEM/WB takes the inputs; MEM_DATA_OUT_REG<=0; MEM_READ_EN_OUT_REG<=0.
- IDLE, op=1:
  - STALL=1.
  - Next edge: state<=WAIT, MEM_REQ<=1, MEM_WE<=~MEM_READ_EN_IN & MEM_WRITE_EN_IN, MEM_ADDR<={ALU_RESULT_IN[WORD_LEN-1:2],2'b00}, MEM_WDATA<=SW_OPERAND_IN, counter<=0.
  - MEM/WB takes a bubble: WB_EN_OUT_REG<=0, MEM_READ_EN_OUT_REG<=0.
- WAIT, MEM_ACK=0:
  - STALL=1; counter increments.
  - MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable.
  - Bubble into MEM/WB each cycle.
- WAIT, MEM_ACK=1 (completion):
  - STALL=0 that cycle, so the upstream pipeline advances at the same edge.
  - At that edge: MEM_REQ<=0, state<=IDLE.
  - MEM/WB takes WB_EN_IN, MEM_READ_EN_IN, PC_IN, ALU_RESULT_IN, DESTINATION_IN. EX/MEM is frozen, so these are still the accessing instruction's values.
  - MEM_DATA_OUT_REG<=MEM_RDATA for a read, 0 for a write.
- WAIT, counter==ACK_TIMEOUT-1 and MEM_ACK=0 (timeout):
  - Treated as completion with MEM_DATA_OUT_REG<=0 and WB_EN_OUT_REG<=0.
  - BUS_ERR<=1 for exactly one cycle. MEM_REQ<=0.
  - If MEM_ACK=1 on the timeout cycle, the ACK wins.
- Minimum memory-op cost is 1 stall cycle (REQ cycle N+1, ACK at N+1). Latency through the block is always 1 edge.
- MEM_ACK in IDLE is ignored.
- Back-to-back memory ops: each op re-enters IDLE for one cycle, then requests again. MEM_REQ is low for at least one cycle between accesses.
- The counter is sized $clog2(ACK_TIMEOUT+1) and never wraps; it saturates at timeout.

Decomposition:
- Shared defines: WORD_LEN, REG_ADDR_LEN, and state encodings IDLE=1'b0, WAIT=1'b1.
- No sub-module. The single FSM + counter + MEM/WB register fits in one file.
- The MEM/WB register is not instantiated separately: its outputs are these *_OUT_REG ports.

Test Plan:
- Reset mid-WAIT: start a load, assert RESET in the 2nd WAIT cycle -> MEM_REQ=0, STALL=0, all outputs 0 next cycle; a later ACK has no effect.
- ALU pass-through: WB_EN=1, DEST=5, ALU=0x0000_002A, no mem op -> STALL stays 0; next cycle WB_EN_OUT_REG=1, DEST_OUT=5, ALU_OUT=0x2A, MEM_DATA_OUT=0.
- Load, ACK after 3 cycles: READ=1, ALU=0x0000_1006, DEST=8 -> MEM_ADDR=0x1004, MEM_WE=0; STALL high 3 cycles; RDATA=0xDEAD_BEEF at ACK -> MEM_DATA_OUT=0xDEADBEEF, MEM_READ_EN_OUT=1, DEST_OUT=8; bubbles (WB_EN_OUT=0) during the wait.
- Store, same-cycle ACK: WRITE=1, ALU=0x20, SW=0x1234_5678 -> MEM_WE=1, MEM_WDATA=0x12345678 for one cycle; STALL for 1 cycle; WB_EN_OUT=0.
- Timeout (ACK_TIMEOUT=4): load, no ACK -> REQ high 4 cycles then drops; BUS_ERR pulses 1 cycle; WB_EN_OUT=0; STALL releases.
- Back-to-back loads plus both-enables case: two consecutive loads -> REQ drops for one cycle between them and each returns the correct RDATA; READ=WRITE=1 -> MEM_WE=0 (read performed).

Source files
------------

// File: rtl/mem_stage_access_pkg.sv
// Shared definitions for the MEM-stage access block of the MIPS32 core.
//   DEF_WORD_LEN / DEF_REG_ADDR_LEN : default data and register-address widths
//   ST_IDLE / ST_WAIT                : FSM state encodings
//   access_is_write()                : load/store decode for the memory request
package mem_stage_access_pkg;

  localparam int DEF_WORD_LEN     = 32;
  localparam int DEF_REG_ADDR_LEN = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // A load and a store flagged together is performed as a load; the store is dropped.
  function automatic logic access_is_write(input logic rd_en, input logic wr_en);
    return ~rd_en & wr_en;
  endfunction

endpackage

// File: rtl/mem_stage_access.sv
// MEM-stage consumer of the EX/MEM pipeline register.
// Runs loads/stores against a variable-latency data memory and drives the
// MEM/WB register fields. Non-memory instructions pass through in one edge.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   *_IN                  EX/MEM register fields (frozen while STALL=1)
//   MEM_REQ/WE/ADDR/WDATA memory request, registered
//   MEM_ACK/MEM_RDATA     memory completion strobe and load data
//   STALL                 combinational; freezes PC/IF/ID/EX/EX-MEM
//   BUS_ERR               one-cycle pulse when an access times out
//   *_OUT_REG             MEM/WB register fields
//   STATE_DBG             current FSM state (0=IDLE, 1=WAIT)
//
// Memory handshake: MEM_REQ rises on the edge that enters WAIT and holds,
// together with MEM_WE/MEM_ADDR/MEM_WDATA, unchanged until the memory
// returns a single-cycle MEM_ACK (MEM_RDATA valid in that same cycle) or the
// wait counter expires. MEM_REQ drops on the completing edge and stays low for
// at least one cycle before the next request. MEM_ACK outside WAIT is ignored.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int WORD_LEN     = DEF_WORD_LEN,
  parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    WB_EN_IN,
  input  logic                    MEM_READ_EN_IN,
  input  logic                    MEM_WRITE_EN_IN,
  input  logic [WORD_LEN-1:0]     PC_IN,
  input  logic [WORD_LEN-1:0]     ALU_RESULT_IN,
  input  logic [WORD_LEN-1:0]     SW_OPERAND_IN,
  input  logic [REG_ADDR_LEN-1:0] DESTINATION_IN,
  output logic                    MEM_REQ,
  output logic                    MEM_WE,
  output logic [WORD_LEN-1:0]     MEM_ADDR,
  output logic [WORD_LEN-1:0]     MEM_WDATA,
  input  logic                    MEM_ACK,
  input  logic [WORD_LEN-1:0]     MEM_RDATA,
  output logic                    STALL,
  output logic                    BUS_ERR,
  output logic                    WB_EN_OUT_REG,
  output logic                    MEM_READ_EN_OUT_REG,
  output logic [WORD_LEN-1:0]     PC_OUT_REG,
  output logic [WORD_LEN-1:0]     ALU_RESULT_OUT_REG,
  output logic [WORD_LEN-1:0]     MEM_DATA_OUT_REG,
  output logic [REG_ADDR_LEN-1:0] DESTINATION_OUT_REG,
  output logic                    STATE_DBG
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [WORD_LEN-1:0]     addr_q, addr_d;
  logic [WORD_LEN-1:0]     wdata_q, wdata_d;
  logic                    bus_err_q, bus_err_d;
  logic                    wb_en_q, wb_en_d;
  logic                    rd_en_q, rd_en_d;
  logic [WORD_LEN-1:0]     pc_q, pc_d;
  logic [WORD_LEN-1:0]     alu_q, alu_d;
  logic [WORD_LEN-1:0]     data_q, data_d;
  logic [REG_ADDR_LEN-1:0] dest_q, dest_d;

  logic op;
  logic in_wait;
  logic timeout_hit;

  assign op          = MEM_READ_EN_IN | MEM_WRITE_EN_IN;
  assign in_wait     = (state_q == ST_WAIT);
  // An ACK arriving on the last allowed cycle takes precedence over the timeout.
  assign timeout_hit = in_wait & ~MEM_ACK & (cnt_q == CNT_LAST);

  // Completion (ACK or timeout) releases the stall in the same cycle so the
  // upstream pipeline advances on the very edge that writes MEM/WB.
  assign STALL = ((state_q == ST_IDLE) & op) | (in_wait & ~MEM_ACK & ~timeout_hit);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bus_err_d = 1'b0;
    wb_en_d   = wb_en_q;
    rd_en_d   = rd_en_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    data_d    = data_q;
    dest_d    = dest_q;

    case (state_q)
      ST_IDLE: begin
        if (op) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = access_is_write(MEM_READ_EN_IN, MEM_WRITE_EN_IN);
          addr_d  = {ALU_RESULT_IN[WORD_LEN-1:2], 2'b00};
          wdata_d = SW_OPERAND_IN;
          // Bubble into MEM/WB while the access is launched.
          wb_en_d = 1'b0;
          rd_en_d = 1'b0;
        end else begin
          wb_en_d = WB_EN_IN;
          rd_en_d = 1'b0;
          pc_d    = PC_IN;
          alu_d   = ALU_RESULT_IN;
          data_d  = '0;
          dest_d  = DESTINATION_IN;
        end
      end
      default: begin
        if (MEM_ACK || timeout_hit) begin
          // EX/MEM has been frozen, so *_IN still describe the accessing instruction.
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = timeout_hit;
          wb_en_d   = MEM_ACK ? WB_EN_IN : 1'b0;
          rd_en_d   = MEM_READ_EN_IN;
          pc_d      = PC_IN;
          alu_d     = ALU_RESULT_IN;
          data_d    = (MEM_ACK && MEM_READ_EN_IN) ? MEM_RDATA : '0;
          dest_d    = DESTINATION_IN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          wb_en_d = 1'b0;
          rd_en_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
      wb_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      data_q    <= '0;
      dest_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_err_q <= bus_err_d;
      wb_en_q   <= wb_en_d;
      rd_en_q   <= rd_en_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
    end
  end

  assign MEM_REQ             = req_q;
  assign MEM_WE              = we_q;
  assign MEM_ADDR            = addr_q;
  assign MEM_WDATA           = wdata_q;
  assign BUS_ERR             = bus_err_q;
  assign WB_EN_OUT_REG       = wb_en_q;
  assign MEM_READ_EN_OUT_REG = rd_en_q;
  assign PC_OUT_REG          = pc_q;
  assign ALU_RESULT_OUT_REG  = alu_q;
  assign MEM_DATA_OUT_REG    = data_q;
  assign DESTINATION_OUT_REG = dest_q;
  assign STATE_DBG           = state_q[0];

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: directed cases followed by a randomized stream
// of ALU ops, loads, stores and load+store combinations with random memory
// latency, including latencies beyond the timeout.
module tb_mem_stage_access;

  localparam int W   = 32;
  localparam int RW  = 5;
  localparam int TMO = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          WB_EN_IN, MEM_READ_EN_IN, MEM_WRITE_EN_IN;
  logic [W-1:0]  PC_IN, ALU_RESULT_IN, SW_OPERAND_IN;
  logic [RW-1:0] DESTINATION_IN;
  logic          MEM_REQ, MEM_WE;
  logic [W-1:0]  MEM_ADDR, MEM_WDATA;
  logic          MEM_ACK;
  logic [W-1:0]  MEM_RDATA;
  logic          STALL, BUS_ERR;
  logic          WB_EN_OUT_REG, MEM_READ_EN_OUT_REG;
  logic [W-1:0]  PC_OUT_REG, ALU_RESULT_OUT_REG, MEM_DATA_OUT_REG;
  logic [RW-1:0] DESTINATION_OUT_REG;
  logic          STATE_DBG;

  // clock / reset
  always #5 CLK = ~CLK;

  mem_stage_access #(.WORD_LEN(W), .REG_ADDR_LEN(RW), .ACK_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_EN_IN(WB_EN_IN), .MEM_READ_EN_IN(MEM_READ_EN_IN), .MEM_WRITE_EN_IN(MEM_WRITE_EN_IN),
    .PC_IN(PC_IN), .ALU_RESULT_IN(ALU_RESULT_IN), .SW_OPERAND_IN(SW_OPERAND_IN),
    .DESTINATION_IN(DESTINATION_IN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .STALL(STALL), .BUS_ERR(BUS_ERR),
    .WB_EN_OUT_REG(WB_EN_OUT_REG), .MEM_READ_EN_OUT_REG(MEM_READ_EN_OUT_REG),
    .PC_OUT_REG(PC_OUT_REG), .ALU_RESULT_OUT_REG(ALU_RESULT_OUT_REG),
    .MEM_DATA_OUT_REG(MEM_DATA_OUT_REG), .DESTINATION_OUT_REG(DESTINATION_OUT_REG),
    .STATE_DBG(STATE_DBG)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ref_mem[16];  // instruction-level view of memory
  logic [W-1:0] dev_mem[16];  // memory as seen over the request bus

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [W-1:0] pc, input logic [W-1:0] alu,
                       input logic [W-1:0] sw, input logic [RW-1:0] dest);
    WB_EN_IN = wb; MEM_READ_EN_IN = rd; MEM_WRITE_EN_IN = wr;
    PC_IN = pc; ALU_RESULT_IN = alu; SW_OPERAND_IN = sw; DESTINATION_IN = dest;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, W'(MEM_REQ), '0);
    chk({tag, "_we"}, W'(MEM_WE), '0);
    chk({tag, "_addr"}, MEM_ADDR, '0);
    chk({tag, "_wdata"}, MEM_WDATA, '0);
    chk({tag, "_buserr"}, W'(BUS_ERR), '0);
    chk({tag, "_wb"}, W'(WB_EN_OUT_REG), '0);
    chk({tag, "_rdout"}, W'(MEM_READ_EN_OUT_REG), '0);
    chk({tag, "_pc"}, PC_OUT_REG, '0);
    chk({tag, "_alu"}, ALU_RESULT_OUT_REG, '0);
    chk({tag, "_data"}, MEM_DATA_OUT_REG, '0);
    chk({tag, "_dest"}, W'(DESTINATION_OUT_REG), '0);
    chk({tag, "_state"}, W'(STATE_DBG), '0);
  endtask

  // One instruction through MEM. Called at a negedge with the block idle.
  // lat = WAIT cycle (1-based) in which the memory acks; lat > TMO means never.
  // Returns at the negedge after the MEM/WB write, the block idle again.
  task automatic run_instr(input logic wb, input logic rd, input logic wr,
                           input logic [W-1:0] pc, input logic [W-1:0] alu,
                           input logic [W-1:0] sw, input logic [RW-1:0] dest,
                           input int lat);
    logic op, acked, is_wr;
    logic [W-1:0] exp_data;
    logic [3:0] idx;
    op       = rd | wr;
    acked    = op && (lat <= TMO);
    is_wr    = wr && !rd;
    exp_data = '0;
    idx      = alu[5:2];
    drive(wb, rd, wr, pc, alu, sw, dest);
    #1;
    chk("stall_issue", W'(STALL), W'(op));
    if (op) begin
      if (rd && acked) exp_q.push_back(ref_mem[idx]);
      if (is_wr && acked) ref_mem[idx] = sw;
      for (int k = 1; k <= TMO; k++) begin
        @(negedge CLK);
        chk("wait_req", W'(MEM_REQ), 1);
        chk("wait_we", W'(MEM_WE), W'(is_wr));
        chk("wait_addr", MEM_ADDR, {alu[W-1:2], 2'b00});
        chk("wait_wdata", MEM_WDATA, sw);
        chk("wait_bubble_wb", W'(WB_EN_OUT_REG), 0);
        chk("wait_bubble_rd", W'(MEM_READ_EN_OUT_REG), 0);
        chk("wait_buserr", W'(BUS_ERR), 0);
        chk("wait_state", W'(STATE_DBG), 1);
        if (k == lat) begin
          MEM_ACK = 1'b1;
          if (MEM_WE) dev_mem[MEM_ADDR[5:2]] = MEM_WDATA;
          else MEM_RDATA = dev_mem[MEM_ADDR[5:2]];
        end
        #1;
        chk("wait_stall", W'(STALL), (k == lat || k == TMO) ? 0 : 1);
        if (k == lat || k == TMO) break;
      end
    end
    @(negedge CLK);
    MEM_ACK   = 1'b0;
    MEM_RDATA = $urandom;
    if (op && rd && acked) exp_data = exp_q.pop_front();
    chk("out_wb", W'(WB_EN_OUT_REG), W'(op ? (acked & wb) : wb));
    chk("out_rd", W'(MEM_READ_EN_OUT_REG), W'(op & rd));
    chk("out_data", MEM_DATA_OUT_REG, exp_data);
    chk("out_pc", PC_OUT_REG, pc);
    chk("out_alu", ALU_RESULT_OUT_REG, alu);
    chk("out_dest", W'(DESTINATION_OUT_REG), W'(dest));
    chk("out_req", W'(MEM_REQ), 0);
    chk("out_buserr", W'(BUS_ERR), W'(op & ~acked));
    chk("out_state", W'(STATE_DBG), 0);
  endtask

  initial begin
    logic [W-1:0] v;
    int kind;
    RESET = 1'b1; MEM_ACK = 1'b0; MEM_RDATA = '0;
    drive(0, 0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      dev_mem[i] = v;
    end
    ref_mem[1] = 32'hDEAD_BEEF;
    dev_mem[1] = 32'hDEAD_BEEF;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RESET = 1'b0;

    // Reset during the second WAIT cycle of a load; a later ACK must be ignored.
    drive(1, 1, 0, 32'h100, 32'h40, '0, 5'd3);
    #1 chk("rst_stall_issue", W'(STALL), 1);
    @(negedge CLK);
    chk("rst_wait1_req", W'(MEM_REQ), 1);
    @(negedge CLK);
    RESET = 1'b1;
    drive(0, 0, 0, '0, '0, '0, '0);
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("rst_mid_stall", W'(STALL), 0);
    chk_all_zero("rst_mid");
    MEM_ACK   = 1'b1;
    MEM_RDATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk_all_zero("late_ack");

    // ALU pass-through
    run_instr(1, 0, 0, 32'h200, 32'h0000_002A, '0, 5'd5, 1);
    // Load with ACK on the third WAIT cycle from address 0x1004
    run_instr(1, 1, 0, 32'h204, 32'h0000_1006, '0, 5'd8, 3);
    // Store with same-cycle ACK
    run_instr(0, 0, 1, 32'h208, 32'h0000_0020, 32'h1234_5678, 5'd0, 1);
    // Timeout: no ACK at all
    run_instr(1, 1, 0, 32'h20C, 32'h0000_0010, '0, 5'd9, TMO + 1);
    // Back-to-back loads, then load+store flagged together
    run_instr(1, 1, 0, 32'h210, 32'h0000_0020, '0, 5'd10, 2);
    run_instr(1, 1, 0, 32'h214, 32'h0000_1004, '0, 5'd11, 1);
    run_instr(1, 1, 1, 32'h218, 32'h0000_0024, 32'hCAFE_F00D, 5'd12, 2);
    // ACK on the timeout cycle wins
    run_instr(1, 1, 0, 32'h21C, 32'h0000_0008, '0, 5'd13, TMO);

    // Randomized stream
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      run_instr(1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3,
                $urandom, $urandom, $urandom, 5'($urandom),
                $urandom_range(1, TMO + 1));
    end

    // Final load sweep to expose stores that landed in the wrong place
    for (int i = 0; i < 16; i++)
      run_instr(1, 1, 0, 32'h300, 32'(i * 4), '0, 5'd1, 1);

    chk("exp_q_drained", W'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
